// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI constants, FSM state encodings and the per-beat address stepping
// helper for the AXI SRAM responder.
package axi_sram_slave_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
    localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // state   | meaning
    // R_IDLE  | waiting for AR handshake
    // R_FETCH | SRAM read issued at current index
    // R_SEND  | beat presented on R, held until rready
    // W_IDLE  | waiting for AW handshake
    // W_DATA  | accepting W beats until wlast
    // W_RESP  | B response presented until bready
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    // WRAP is not supported and steps like INCR; sizes above 4 bytes clamp to 4.
    function automatic logic [31:0] axi_next_addr(input logic [31:0] addr,
                                                  input logic [2:0]  size,
                                                  input logic [1:0]  burst);
        logic [1:0] eff_size;
        eff_size = (size > 3'd2) ? 2'd2 : size[1:0];
        if (burst == AXI_BURST_FIXED)
            return addr;
        return addr + (32'd1 << eff_size);
    endfunction

endpackage

// File: rtl/axi_sram_slave_sram.sv
// 1-write/1-read word SRAM with byte enables and a registered read port.
// Same-index read and write in one cycle returns the old word.
module sram_1w1r #(
    parameter int IDX_W = 12
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_widx,
    input  logic [3:0]       i_wstrb,
    input  logic [31:0]      i_wdata,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_ridx,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [2**IDX_W];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wstrb[b])
                    r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_re)
            r_rdata <= r_mem[i_ridx];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 responder backed by a word-addressed on-chip SRAM, with independent
// read and write engines; one outstanding transaction per direction.
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int ID_W     = 4,
    parameter int IDX_W    = 12,
    parameter int BASE_CHK = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [ID_W-1:0] i_awid,
    input  logic [31:0]     i_awaddr,
    input  logic [7:0]      i_awlen,
    input  logic [2:0]      i_awsize,
    input  logic [1:0]      i_awburst,
    input  logic            i_awvalid,
    output logic            o_awready,
    input  logic [31:0]     i_wdata,
    input  logic [3:0]      i_wstrb,
    input  logic            i_wlast,
    input  logic            i_wvalid,
    output logic            o_wready,
    output logic [ID_W-1:0] o_bid,
    output logic [1:0]      o_bresp,
    output logic            o_bvalid,
    input  logic            i_bready,
    input  logic [ID_W-1:0] i_arid,
    input  logic [31:0]     i_araddr,
    input  logic [7:0]      i_arlen,
    input  logic [2:0]      i_arsize,
    input  logic [1:0]      i_arburst,
    input  logic            i_arvalid,
    output logic            o_arready,
    output logic [ID_W-1:0] o_rid,
    output logic [31:0]     o_rdata,
    output logic [1:0]      o_rresp,
    output logic            o_rlast,
    output logic            o_rvalid,
    input  logic            i_rready
);

    r_state_t        r_rstate, w_rstate_nxt;
    logic [ID_W-1:0] r_rid;
    logic [31:0]     r_raddr;
    logic [7:0]      r_rcnt;
    logic [2:0]      r_rsize;
    logic [1:0]      r_rburst;

    w_state_t        r_wstate, w_wstate_nxt;
    logic [ID_W-1:0] r_wid;
    logic [31:0]     r_waddr;
    logic [2:0]      r_wsize;
    logic [1:0]      r_wburst;
    logic            r_werr;

    logic            w_r_oor, w_w_oor, w_we;
    logic [31:0]     w_sram_rdata;
    logic            w_unused;

    // Write bursts end on wlast alone, so awlen has no consumer.
    assign w_unused = ^i_awlen;

    assign w_r_oor = (BASE_CHK != 0) && (r_raddr[31:IDX_W+2] != '0);
    assign w_w_oor = (BASE_CHK != 0) && (r_waddr[31:IDX_W+2] != '0);

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (i_arvalid) w_rstate_nxt = R_FETCH;
            R_FETCH: w_rstate_nxt = R_SEND;
            R_SEND:  if (i_rready) w_rstate_nxt = (r_rcnt == 8'd0) ? R_IDLE : R_FETCH;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rstate <= R_IDLE;
            r_rid    <= '0;
            r_raddr  <= '0;
            r_rcnt   <= '0;
            r_rsize  <= '0;
            r_rburst <= '0;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (r_rstate == R_IDLE && i_arvalid) begin
                r_rid    <= i_arid;
                r_raddr  <= i_araddr;
                r_rcnt   <= i_arlen;
                r_rsize  <= i_arsize;
                r_rburst <= i_arburst;
            end else if (r_rstate == R_SEND && i_rready && r_rcnt != 8'd0) begin
                r_rcnt  <= r_rcnt - 8'd1;
                r_raddr <= axi_next_addr(r_raddr, r_rsize, r_rburst);
            end
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (i_awvalid) w_wstate_nxt = W_DATA;
            W_DATA:  if (i_wvalid && i_wlast) w_wstate_nxt = W_RESP;
            W_RESP:  if (i_bready) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate <= W_IDLE;
            r_wid    <= '0;
            r_waddr  <= '0;
            r_wsize  <= '0;
            r_wburst <= '0;
            r_werr   <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nxt;
            if (r_wstate == W_IDLE && i_awvalid) begin
                r_wid    <= i_awid;
                r_waddr  <= i_awaddr;
                r_wsize  <= i_awsize;
                r_wburst <= i_awburst;
                r_werr   <= 1'b0;
            end else if (r_wstate == W_DATA && i_wvalid) begin
                if (w_w_oor)
                    r_werr <= 1'b1;
                r_waddr <= axi_next_addr(r_waddr, r_wsize, r_wburst);
            end
        end
    end

    assign w_we = (r_wstate == W_DATA) && i_wvalid && !w_w_oor;

    sram_1w1r #(.IDX_W(IDX_W)) u_sram (
        .clk     (clk),
        .i_we    (w_we),
        .i_widx  (r_waddr[IDX_W+1:2]),
        .i_wstrb (i_wstrb),
        .i_wdata (i_wdata),
        .i_re    (r_rstate == R_FETCH),
        .i_ridx  (r_raddr[IDX_W+1:2]),
        .o_rdata (w_sram_rdata)
    );

    // The SRAM read register only loads in R_FETCH, so it holds the beat in R_SEND.
    assign o_arready = (r_rstate == R_IDLE);
    assign o_rvalid  = (r_rstate == R_SEND);
    assign o_rid     = r_rid;
    assign o_rlast   = o_rvalid && (r_rcnt == 8'd0);
    assign o_rresp   = (o_rvalid && w_r_oor) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign o_rdata   = (o_rvalid && !w_r_oor) ? w_sram_rdata : 32'd0;

    assign o_awready = (r_wstate == W_IDLE);
    assign o_wready  = (r_wstate == W_DATA);
    assign o_bvalid  = (r_wstate == W_RESP);
    assign o_bid     = r_wid;
    assign o_bresp   = (o_bvalid && r_werr) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: tasks push expected B/R responses,
// a negedge monitor pops and compares them on each handshake.
module tb_axi_sram_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  i_awid = '0;
    logic [31:0] i_awaddr = '0;
    logic [7:0]  i_awlen = '0;
    logic [2:0]  i_awsize = 3'd2;
    logic [1:0]  i_awburst = 2'd1;
    logic        i_awvalid = 1'b0;
    logic        o_awready;
    logic [31:0] i_wdata = '0;
    logic [3:0]  i_wstrb = '0;
    logic        i_wlast = 1'b0;
    logic        i_wvalid = 1'b0;
    logic        o_wready;
    logic [3:0]  o_bid;
    logic [1:0]  o_bresp;
    logic        o_bvalid;
    logic        i_bready = 1'b1;
    logic [3:0]  i_arid = '0;
    logic [31:0] i_araddr = '0;
    logic [7:0]  i_arlen = '0;
    logic [2:0]  i_arsize = 3'd2;
    logic [1:0]  i_arburst = 2'd1;
    logic        i_arvalid = 1'b0;
    logic        o_arready;
    logic [3:0]  o_rid;
    logic [31:0] o_rdata;
    logic [1:0]  o_rresp;
    logic        o_rlast;
    logic        o_rvalid;
    logic        i_rready = 1'b1;

    always #5 clk = ~clk;

    axi_sram_slave #(.ID_W(4), .IDX_W(12), .BASE_CHK(1)) dut (
        .clk(clk), .reset(reset),
        .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize),
        .i_awburst(i_awburst), .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid),
        .o_wready(o_wready),
        .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
        .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
        .i_arburst(i_arburst), .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
        .o_rvalid(o_rvalid), .i_rready(i_rready)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    r_exp_t r_q[$];
    b_exp_t b_q[$];
    r_exp_t r_e;
    b_exp_t b_e;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // rready pattern 1,0,0,1 repeating, one step per cycle, when enabled
    logic rr_toggle = 1'b0;
    int   rr_ph = 0;
    always @(posedge clk) begin
        #1;
        if (rr_toggle) begin
            i_rready = ((rr_ph % 4) == 0) || ((rr_ph % 4) == 3);
            rr_ph++;
        end else begin
            i_rready = 1'b1;
        end
    end

    logic        hold_v = 1'b0;
    logic [31:0] hold_d = '0;

    always @(negedge clk) begin
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (o_bvalid && i_bready) begin
                if (b_q.size() == 0) begin
                    fail_now("b_unexpected");
                end else begin
                    b_e = b_q.pop_front();
                    chk("bid", 64'(o_bid), 64'(b_e.id));
                    chk("bresp", 64'(o_bresp), 64'(b_e.resp));
                end
            end
            if (hold_v && o_rvalid)
                chk("rdata_hold", 64'(o_rdata), 64'(hold_d));
            if (o_rvalid && i_rready) begin
                if (r_q.size() == 0) begin
                    fail_now("r_unexpected");
                end else begin
                    r_e = r_q.pop_front();
                    chk("rid", 64'(o_rid), 64'(r_e.id));
                    chk("rdata", 64'(o_rdata), 64'(r_e.data));
                    chk("rresp", 64'(o_rresp), 64'(r_e.resp));
                    chk("rlast", 64'(o_rlast), 64'(r_e.last));
                end
            end
            hold_v = o_rvalid && !i_rready;
            hold_d = o_rdata;
        end
    end

    // which: 0=AW, 1=W, 2=AR; returns just after the accepting clock edge
    task automatic wait_hs(input int which, input string name);
        int  n;
        logic rdy;
        n = 0;
        @(negedge clk);
        rdy = (which == 0) ? o_awready : (which == 1) ? o_wready : o_arready;
        while (!rdy && n < 100) begin
            @(negedge clk);
            rdy = (which == 0) ? o_awready : (which == 1) ? o_wready : o_arready;
            n++;
        end
        if (!rdy) fail_now(name);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((r_q.size() != 0 || b_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (r_q.size() != 0 || b_q.size() != 0) begin
            fail_now("response_timeout");
            r_q.delete();
            b_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [1:0] burst, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [31:0] d2, input logic [31:0] d3, input logic [3:0] strb,
                      input logic [1:0] resp);
        logic [31:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        b_q.push_back('{id: id, resp: resp});
        i_awid = id; i_awaddr = addr; i_awlen = len; i_awsize = 3'd2; i_awburst = burst;
        i_awvalid = 1'b1;
        wait_hs(0, "aw_timeout");
        i_awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            i_wdata = d[i]; i_wstrb = strb; i_wlast = (i == int'(len)); i_wvalid = 1'b1;
            wait_hs(1, "w_timeout");
            i_wvalid = 1'b0;
            i_wlast = 1'b0;
        end
        wait_idle();
    endtask

    task automatic issue_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst);
        i_arid = id; i_araddr = addr; i_arlen = len; i_arsize = 3'd2; i_arburst = burst;
        i_arvalid = 1'b1;
        wait_hs(2, "ar_timeout");
        i_arvalid = 1'b0;
    endtask

    task automatic rd1(input logic [3:0] id, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] resp);
        r_q.push_back('{id: id, data: data, resp: resp, last: 1'b1});
        issue_ar(id, addr, 8'd0, 2'd1);
        wait_idle();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 64'(o_awready), 64'd1);
        chk("rst_arready", 64'(o_arready), 64'd1);
        chk("rst_wready", 64'(o_wready), 64'd0);
        chk("rst_bvalid", 64'(o_bvalid), 64'd0);
        chk("rst_rvalid", 64'(o_rvalid), 64'd0);
        chk("rst_rlast", 64'(o_rlast), 64'd0);
        chk("rst_payload", 64'({o_bresp, o_rresp, o_bid, o_rid, o_rdata}), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // single write then read
        wr(4'h3, 32'h10, 8'd0, 2'd1, 32'hDEADBEEF, 0, 0, 0, 4'hF, 2'b00);
        rd1(4'h5, 32'h10, 32'hDEADBEEF, 2'b00);

        // INCR burst of 4, read back with rready toggling
        wr(4'h1, 32'h100, 8'd3, 2'd1, 32'd1, 32'd2, 32'd3, 32'd4, 4'hF, 2'b00);
        for (int i = 0; i < 4; i++)
            r_q.push_back('{id: 4'h2, data: 32'(i + 1), resp: 2'b00, last: (i == 3)});
        rr_ph = 0;
        rr_toggle = 1'b1;
        issue_ar(4'h2, 32'h100, 8'd3, 2'd1);
        wait_idle();
        rr_toggle = 1'b0;

        // byte strobes
        wr(4'h4, 32'h20, 8'd0, 2'd1, 32'h11223344, 0, 0, 0, 4'hF, 2'b00);
        wr(4'h4, 32'h20, 8'd0, 2'd1, 32'hAABBCCDD, 0, 0, 0, 4'b0101, 2'b00);
        rd1(4'h6, 32'h20, 32'h11BB33DD, 2'b00);

        // FIXED burst lands every beat on the same word
        wr(4'h7, 32'h44, 8'd0, 2'd1, 32'h55555555, 0, 0, 0, 4'hF, 2'b00);
        wr(4'h8, 32'h40, 8'd2, 2'd0, 32'hA, 32'hB, 32'hC, 0, 4'hF, 2'b00);
        rd1(4'h9, 32'h40, 32'hC, 2'b00);
        rd1(4'h9, 32'h44, 32'h55555555, 2'b00);

        // out-of-range access
        wr(4'hA, 32'h0, 8'd0, 2'd1, 32'hCAFE0000, 0, 0, 0, 4'hF, 2'b00);
        wr(4'hB, 32'h4000, 8'd0, 2'd1, 32'h12345678, 0, 0, 0, 4'hF, 2'b10);
        rd1(4'hC, 32'h4000, 32'h0, 2'b10);
        rd1(4'hC, 32'h0, 32'hCAFE0000, 2'b00);

        // INCR burst crossing the top of the SRAM into the error region
        wr(4'hD, 32'h3FFC, 8'd0, 2'd1, 32'hDDDD0001, 0, 0, 0, 4'hF, 2'b00);
        r_q.push_back('{id: 4'hE, data: 32'hDDDD0001, resp: 2'b00, last: 1'b0});
        r_q.push_back('{id: 4'hE, data: 32'h0, resp: 2'b10, last: 1'b1});
        issue_ar(4'hE, 32'h3FFC, 8'd1, 2'd1);
        wait_idle();

        // reset after beat 2 of a len-7 read
        r_q.push_back('{id: 4'hF, data: 32'd1, resp: 2'b00, last: 1'b0});
        r_q.push_back('{id: 4'hF, data: 32'd2, resp: 2'b00, last: 1'b0});
        issue_ar(4'hF, 32'h100, 8'd7, 2'd1);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!(o_rvalid && i_rready && r_q.size() <= 1) && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) fail_now("beat2_timeout");
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_rvalid", 64'(o_rvalid), 64'd0);
        chk("mid_rst_arready", 64'(o_arready), 64'd1);
        chk("mid_rst_beats_left", 64'(r_q.size()), 64'd0);
        r_q.delete();
        @(posedge clk);
        #1;
        rd1(4'h1, 32'h10, 32'hDEADBEEF, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
